// File: rtl/calc1_port_arbiter.sv
// Shares one calc1 ALU between NUM_PORTS two-cycle requester ports.
// Round-robin grant, valid/ready issue, per-port one-cycle response pulse with WAIT timeout.
module calc1_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                    c_clk,
    input  logic                    reset,
    input  logic [4*NUM_PORTS-1:0]  req_cmd_in,
    input  logic [DW*NUM_PORTS-1:0] req_data_in,
    output logic [2*NUM_PORTS-1:0]  out_resp,
    output logic [DW*NUM_PORTS-1:0] out_data,
    output logic [NUM_PORTS-1:0]    port_busy,
    output logic                    alu_valid_out,
    input  logic                    alu_ready_in,
    output logic [3:0]              alu_cmd_out,
    output logic [DW-1:0]           alu_data1_out,
    output logic [DW-1:0]           alu_data2_out,
    input  logic                    alu_resp_valid_in,
    input  logic [1:0]              alu_resp_in,
    input  logic [DW-1:0]           alu_data_in
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_OP2  = 2'd1;
    localparam logic [1:0] P_PEND = 2'd2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]           pstate [NUM_PORTS];
    logic [3:0]           cmd_q  [NUM_PORTS];
    logic [DW-1:0]        op1_q  [NUM_PORTS];
    logic [DW-1:0]        op2_q  [NUM_PORTS];

    logic [1:0]           sstate;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant_q;
    logic [CW-1:0]        wait_cnt;

    logic [NUM_PORTS-1:0] pend;
    logic [PW-1:0]        pick_hi;
    logic [PW-1:0]        pick_lo;
    logic                 hi_found;
    logic                 lo_found;
    logic [PW-1:0]        pick;
    logic                 pick_found;
    logic                 resp_done;
    logic                 timed_out;

    always_comb begin
        pend = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            pend[p] = (pstate[p] == P_PEND);
        end
    end

    assign port_busy = pend;

    // First pending port at or after the pointer, else the first pending port overall (wrap).
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (pend[p] && !hi_found && (PW'(p) >= rr_ptr)) begin
                hi_found = 1'b1;
                pick_hi  = PW'(p);
            end
            if (pend[p] && !lo_found) begin
                lo_found = 1'b1;
                pick_lo  = PW'(p);
            end
        end
        pick       = hi_found ? pick_hi : pick_lo;
        pick_found = hi_found | lo_found;
    end

    assign resp_done = (sstate == S_WAIT) && (alu_resp_valid_in || (wait_cnt == TO_LAST));
    assign timed_out = (sstate == S_WAIT) && !alu_resp_valid_in && (wait_cnt == TO_LAST);

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                pstate[p] <= P_IDLE;
                cmd_q[p]  <= '0;
                op1_q[p]  <= '0;
                op2_q[p]  <= '0;
            end
            sstate        <= S_IDLE;
            rr_ptr        <= '0;
            grant_q       <= '0;
            wait_cnt      <= '0;
            alu_valid_out <= 1'b0;
            alu_cmd_out   <= '0;
            alu_data1_out <= '0;
            alu_data2_out <= '0;
            out_resp      <= '0;
            out_data      <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                case (pstate[p])
                    P_IDLE: begin
                        if (req_cmd_in[4*p +: 4] != 4'd0) begin
                            cmd_q[p]  <= req_cmd_in[4*p +: 4];
                            op1_q[p]  <= req_data_in[DW*p +: DW];
                            pstate[p] <= P_OP2;
                        end
                    end
                    P_OP2: begin
                        op2_q[p]  <= req_data_in[DW*p +: DW];
                        pstate[p] <= P_PEND;
                    end
                    P_PEND: begin
                        if (resp_done && (grant_q == PW'(p))) begin
                            pstate[p] <= P_IDLE;
                        end
                    end
                    default: pstate[p] <= P_IDLE;
                endcase

                if (resp_done && (grant_q == PW'(p))) begin
                    out_resp[2*p +: 2]   <= timed_out ? 2'b11 : alu_resp_in;
                    out_data[DW*p +: DW] <= timed_out ? '0 : alu_data_in;
                end else begin
                    out_resp[2*p +: 2]   <= 2'b00;
                    out_data[DW*p +: DW] <= '0;
                end
            end

            case (sstate)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q       <= pick;
                        alu_cmd_out   <= cmd_q[pick];
                        alu_data1_out <= op1_q[pick];
                        alu_data2_out <= op2_q[pick];
                        alu_valid_out <= 1'b1;
                        sstate        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_ready_in) begin
                        alu_valid_out <= 1'b0;
                        wait_cnt      <= '0;
                        sstate        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_done) begin
                        rr_ptr <= (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
                        sstate <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: sstate <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_arbiter.sv
// Scoreboard bench for calc1_port_arbiter: directed port requests, a behavioural ALU
// that checks each issued request, and a monitor that matches every response pulse.
module tb_calc1_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TO = 64;

    logic               c_clk = 1'b0;
    logic               reset;
    logic [4*NP-1:0]    req_cmd_in;
    logic [DW*NP-1:0]   req_data_in;
    logic [2*NP-1:0]    out_resp;
    logic [DW*NP-1:0]   out_data;
    logic [NP-1:0]      port_busy;
    logic               alu_valid_out;
    logic               alu_ready_in;
    logic [3:0]         alu_cmd_out;
    logic [DW-1:0]      alu_data1_out;
    logic [DW-1:0]      alu_data2_out;
    logic               alu_resp_valid_in;
    logic [1:0]         alu_resp_in;
    logic [DW-1:0]      alu_data_in;

    calc1_port_arbiter #(.NUM_PORTS(NP), .DW(DW), .TIMEOUT(TO)) dut (
        .c_clk             (c_clk),
        .reset             (reset),
        .req_cmd_in        (req_cmd_in),
        .req_data_in       (req_data_in),
        .out_resp          (out_resp),
        .out_data          (out_data),
        .port_busy         (port_busy),
        .alu_valid_out     (alu_valid_out),
        .alu_ready_in      (alu_ready_in),
        .alu_cmd_out       (alu_cmd_out),
        .alu_data1_out     (alu_data1_out),
        .alu_data2_out     (alu_data2_out),
        .alu_resp_valid_in (alu_resp_valid_in),
        .alu_resp_in       (alu_resp_in),
        .alu_data_in       (alu_data_in)
    );

    always #5 c_clk = ~c_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0]    cmd;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } gnt_t;

    exp_t sb_q[$];
    gnt_t gq[$];

    logic alu_ready_en = 1'b1;
    logic alu_mute     = 1'b0;
    logic force_strobe = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] cmd, input logic [DW-1:0] data);
        req_cmd_in[4*p +: 4]   = cmd;
        req_data_in[DW*p +: DW] = data;
    endtask

    task automatic push_exp(input int p, input logic [1:0] r, input logic [DW-1:0] d, input int c);
        exp_t e;
        e.port = p; e.resp = r; e.data = d; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic push_gnt(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        gnt_t g;
        g.cmd = c; g.op1 = a; g.op2 = b;
        gq.push_back(g);
    endtask

    // Two-cycle protocol on one port; t0 is the cycle carrying the command.
    task automatic send(input int p, input logic [3:0] cmd, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, output int t0);
        tick();
        t0 = cyc;
        set_port(p, cmd, a);
        tick();
        set_port(p, 4'd0, b);
        tick();
        set_port(p, 4'd0, '0);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || gq.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_responses", 64'(sb_q.size()), 64'd0);
        chk("drain_grants", 64'(gq.size()), 64'd0);
        sb_q.delete();
        gq.delete();
        tick();
        tick();
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        @(negedge c_clk);
        while (!alu_valid_out && n < limit) begin
            @(negedge c_clk);
            n++;
        end
        chk("valid_seen", 64'(alu_valid_out), 64'd1);
    endtask

    // Response monitor
    initial begin
        forever begin
            @(negedge c_clk);
            for (int p = 0; p < NP; p++) begin
                logic [1:0] r;
                r = out_resp[2*p +: 2];
                if (r != 2'b00) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: port %0d got resp %0b data 0x%0h, expected none (cycle %0d)",
                                 p, r, out_data[DW*p +: DW], cyc);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("resp_port", 64'(p), 64'(e.port));
                        chk("resp_code", 64'(r), 64'(e.resp));
                        chk("resp_data", 64'(out_data[DW*p +: DW]), 64'(e.data));
                        if (e.cyc >= 0) chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    // Behavioural ALU: checks each accepted request, answers one cycle later
    initial begin
        alu_ready_in      = 1'b0;
        alu_resp_valid_in = 1'b0;
        alu_resp_in       = 2'b00;
        alu_data_in       = '0;
        forever begin
            logic          hs;
            logic [3:0]    c;
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            logic [DW:0]   s;
            @(negedge c_clk);
            hs = alu_valid_out && alu_ready_in;
            c = alu_cmd_out; a = alu_data1_out; b = alu_data2_out;
            if (hs) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: cmd %0d op1 %0d op2 %0d, expected no request (cycle %0d)",
                             c, a, b, cyc);
                end else begin
                    gnt_t g;
                    g = gq.pop_front();
                    chk("grant_cmd", 64'(c), 64'(g.cmd));
                    chk("grant_op1", 64'(a), 64'(g.op1));
                    chk("grant_op2", 64'(b), 64'(g.op2));
                end
            end
            @(posedge c_clk);
            #1;
            alu_resp_valid_in = 1'b0;
            alu_resp_in       = 2'b00;
            alu_data_in       = '0;
            if (force_strobe) begin
                alu_resp_valid_in = 1'b1;
                alu_resp_in       = 2'b01;
                alu_data_in       = 32'd55;
                force_strobe      = 1'b0;
            end else if (hs && !alu_mute) begin
                alu_resp_valid_in = 1'b1;
                case (c)
                    4'd1: begin
                        s = {1'b0, a} + {1'b0, b};
                        alu_resp_in = s[DW] ? 2'b10 : 2'b01;
                        alu_data_in = s[DW] ? '0 : s[DW-1:0];
                    end
                    4'd2: begin
                        alu_resp_in = (a < b) ? 2'b10 : 2'b01;
                        alu_data_in = (a < b) ? '0 : a - b;
                    end
                    default: begin
                        alu_resp_in = 2'b10;
                        alu_data_in = '0;
                    end
                endcase
            end
            alu_ready_in = alu_ready_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        reset       = 1'b1;
        req_cmd_in  = '0;
        req_data_in = '0;
        repeat (3) tick();
        @(negedge c_clk);
        chk("rst_out_resp", 64'(out_resp), 64'd0);
        chk("rst_out_data", 64'(|out_data), 64'd0);
        chk("rst_port_busy", 64'(port_busy), 64'd0);
        chk("rst_alu_valid", 64'(alu_valid_out), 64'd0);
        chk("rst_alu_cmd", 64'(alu_cmd_out), 64'd0);
        tick();
        reset = 1'b0;

        // All four ports at once from pointer 0: served 0,1,2,3
        for (int p = 0; p < NP; p++) begin
            push_gnt(4'd1, DW'(p), 32'd1);
            push_exp(p, 2'b01, DW'(p + 1), -1);
        end
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd1, DW'(p));
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd1);
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, '0);
        drain(200);

        // Pointer back at 0: ports 2 and 0 pending -> 0 first
        push_gnt(4'd1, 32'd10, 32'd1);
        push_gnt(4'd1, 32'd20, 32'd2);
        push_exp(0, 2'b01, 32'd11, -1);
        push_exp(2, 2'b01, 32'd22, -1);
        tick();
        set_port(0, 4'd1, 32'd10); set_port(2, 4'd1, 32'd20);
        tick();
        set_port(0, 4'd0, 32'd1);  set_port(2, 4'd0, 32'd2);
        tick();
        set_port(0, 4'd0, '0);     set_port(2, 4'd0, '0);
        drain(100);

        // Pointer now 3: ports 0 and 3 pending -> 3 first, then wrap to 0
        push_gnt(4'd1, 32'd30, 32'd3);
        push_gnt(4'd1, 32'd4, 32'd4);
        push_exp(3, 2'b01, 32'd33, -1);
        push_exp(0, 2'b01, 32'd8, -1);
        tick();
        set_port(0, 4'd1, 32'd4);  set_port(3, 4'd1, 32'd30);
        tick();
        set_port(0, 4'd0, 32'd4);  set_port(3, 4'd0, 32'd3);
        tick();
        set_port(0, 4'd0, '0);     set_port(3, 4'd0, '0);
        drain(100);

        // Single port add with best-case latency: response visible in cycle 5
        push_gnt(4'd1, 32'd5, 32'd7);
        send(0, 4'd1, 32'd5, 32'd7, t0);
        push_exp(0, 2'b01, 32'd12, t0 + 5);
        drain(50);

        // Handshake stall: request held stable while ready is low
        alu_ready_en = 1'b0;
        tick();
        push_gnt(4'd1, 32'd100, 32'd23);
        send(1, 4'd1, 32'd100, 32'd23, t0);
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            chk("stall_valid", 64'(alu_valid_out), 64'd1);
            chk("stall_cmd", 64'(alu_cmd_out), 64'd1);
            chk("stall_op1", 64'(alu_data1_out), 64'd100);
            chk("stall_op2", 64'(alu_data2_out), 64'd23);
            chk("stall_no_resp", 64'(out_resp), 64'd0);
        end
        push_exp(1, 2'b01, 32'd123, -1);
        alu_ready_en = 1'b1;
        drain(50);

        // ALU error code passes through (3 - 5 underflows)
        push_gnt(4'd2, 32'd3, 32'd5);
        push_exp(2, 2'b10, 32'd0, -1);
        send(2, 4'd2, 32'd3, 32'd5, t0);
        drain(50);

        // No ALU response: timeout after TIMEOUT cycles in WAIT
        alu_mute = 1'b1;
        push_gnt(4'd1, 32'd1, 32'd1);
        send(3, 4'd1, 32'd1, 32'd1, t0);
        push_exp(3, 2'b11, 32'd0, t0 + 4 + TO);
        drain(200);
        alu_mute = 1'b0;

        // Command on a busy port is ignored
        alu_ready_en = 1'b0;
        push_gnt(4'd1, 32'd1, 32'd1);
        push_gnt(4'd1, 32'd40, 32'd2);
        send(0, 4'd1, 32'd1, 32'd1, t0);
        wait_valid(20);
        send(1, 4'd1, 32'd40, 32'd2, t0);
        tick();
        send(1, 4'd1, 32'd99, 32'd7, t0);
        @(negedge c_clk);
        chk("busy_during_pend", 64'(port_busy), 64'h3);
        push_exp(0, 2'b01, 32'd2, -1);
        push_exp(1, 2'b01, 32'd42, -1);
        alu_ready_en = 1'b1;
        drain(60);
        @(negedge c_clk);
        chk("busy_cleared", 64'(port_busy), 64'd0);

        // Reset during WAIT, then a stale strobe: nothing may come out
        alu_mute = 1'b1;
        push_gnt(4'd1, 32'd5, 32'd5);
        send(0, 4'd1, 32'd5, 32'd5, t0);
        for (int i = 0; i < 20 && gq.size() != 0; i++) tick();
        chk("rst_mid_issued", 64'(gq.size()), 64'd0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        force_strobe = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge c_clk);
            chk("rst_mid_resp", 64'(out_resp), 64'd0);
            chk("rst_mid_data", 64'(|out_data), 64'd0);
            chk("rst_mid_valid", 64'(alu_valid_out), 64'd0);
            chk("rst_mid_busy", 64'(port_busy), 64'd0);
            chk("rst_mid_bus", 64'(alu_cmd_out), 64'd0);
        end
        alu_mute = 1'b0;
        tick();

        // Normal operation after reset
        push_gnt(4'd1, 32'd8, 32'd9);
        send(2, 4'd1, 32'd8, 32'd9, t0);
        push_exp(2, 2'b01, 32'd17, t0 + 5);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
